// File: rtl/snake_head_ctrl_if.sv
// Signal bundle between the snake game controller and the LED matrix / input logic.
// The controller side uses modport slave; the driving side (buttons, matrix) uses master.
interface snake_head_ctrl_if;
    logic       btn_L;
    logic       btn_R;
    logic       btn_U;
    logic       btn_D;
    logic       start;
    logic       next_occupied;
    logic [3:0] next_row;
    logic [3:0] next_col;
    logic [3:0] head_row;
    logic [3:0] head_col;
    logic       L;
    logic       R;
    logic       U;
    logic       D;
    logic       tracking;
    logic [5:0] snake_length;
    logic       hit_score;
    logic       gameover;
    logic [3:0] food_row;
    logic [3:0] food_col;

    modport master (
        output btn_L, btn_R, btn_U, btn_D, start, next_occupied,
        input  next_row, next_col, head_row, head_col, L, R, U, D,
               tracking, snake_length, hit_score, gameover, food_row, food_col
    );

    modport slave (
        input  btn_L, btn_R, btn_U, btn_D, start, next_occupied,
        output next_row, next_col, head_row, head_col, L, R, U, D,
               tracking, snake_length, hit_score, gameover, food_row, food_col
    );
endinterface

// File: rtl/snake_head_ctrl.sv
// Snake game controller: IDLE/RUN/OVER state machine, step divider, head/direction,
// food placement from an 8-bit LFSR, and length bookkeeping for the 16x16 matrix.
module snake_head_ctrl #(
    parameter int TICK_DIV  = 12_500_000,
    parameter int START_LEN = 3,
    parameter int MAX_LEN   = 63
) (
    input logic               Clock,
    input logic               reset,
    snake_head_ctrl_if.slave  bus
);
    localparam int              CW          = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   TICK_LAST   = CW'(TICK_DIV - 1);
    localparam logic [5:0]      START_LEN_V = 6'(START_LEN);
    localparam logic [5:0]      MAX_LEN_V   = 6'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    // Opposite directions share bit 1 and differ in bit 0.
    typedef enum logic [1:0] {DIR_R = 2'b00, DIR_L = 2'b01, DIR_U = 2'b10, DIR_D = 2'b11} dir_t;

    state_t        state_reg, state_next;
    dir_t          dir_reg, pend_reg, press_dir;
    logic          press_valid;
    logic [3:0]    head_row_reg, head_col_reg, food_row_reg, food_col_reg;
    logic [5:0]    len_reg;
    logic [CW-1:0] tick_reg;
    logic [7:0]    lfsr_reg;
    logic          tracking_reg, hit_reg;
    logic [4:0]    nxt_row5, nxt_col5;
    logic          wall, step_cycle, step_ok, step_fail, food_hit;
    logic [3:0]    start_food_col, hit_food_col;

    function automatic logic opposite(dir_t a, dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    always_comb begin
        press_valid = 1'b1;
        press_dir   = DIR_R;
        if (bus.btn_U)      press_dir = DIR_U;
        else if (bus.btn_D) press_dir = DIR_D;
        else if (bus.btn_L) press_dir = DIR_L;
        else if (bus.btn_R) press_dir = DIR_R;
        else                press_valid = 1'b0;
    end

    // Bit 4 of the widened coordinate flags both underflow (-1) and overflow (16).
    always_comb begin
        nxt_row5 = {1'b0, head_row_reg};
        nxt_col5 = {1'b0, head_col_reg};
        unique case (pend_reg)
            DIR_R: nxt_col5 = {1'b0, head_col_reg} + 5'd1;
            DIR_L: nxt_col5 = {1'b0, head_col_reg} - 5'd1;
            DIR_U: nxt_row5 = {1'b0, head_row_reg} - 5'd1;
            DIR_D: nxt_row5 = {1'b0, head_row_reg} + 5'd1;
        endcase
    end

    assign wall       = nxt_row5[4] | nxt_col5[4];
    assign step_cycle = (state_reg == RUN) && (tick_reg == TICK_LAST);
    assign step_fail  = step_cycle && (wall || bus.next_occupied);
    assign step_ok    = step_cycle && !wall && !bus.next_occupied;
    assign food_hit   = step_ok && (nxt_row5[3:0] == food_row_reg) && (nxt_col5[3:0] == food_col_reg);

    assign start_food_col = (lfsr_reg == 8'h88) ? lfsr_reg[3:0] + 4'd1 : lfsr_reg[3:0];
    assign hit_food_col   = (lfsr_reg == {nxt_row5[3:0], nxt_col5[3:0]}) ? lfsr_reg[3:0] + 4'd1
                                                                         : lfsr_reg[3:0];

    always_ff @(posedge Clock) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (step_fail) state_next = OVER;
            OVER:    if (bus.start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The LFSR keeps running across games so successive food sequences differ.
    always_ff @(posedge Clock) begin
        if (!reset) lfsr_reg <= 8'h5A;
        else        lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end

    always_ff @(posedge Clock) begin
        if (!reset || (state_reg == OVER && bus.start)) begin
            head_row_reg <= 4'd8;
            head_col_reg <= 4'd8;
            dir_reg      <= DIR_R;
            pend_reg     <= DIR_R;
            len_reg      <= START_LEN_V;
            food_row_reg <= 4'd0;
            food_col_reg <= 4'd0;
            tick_reg     <= '0;
            tracking_reg <= 1'b0;
            hit_reg      <= 1'b0;
        end else begin
            tracking_reg <= 1'b0;
            hit_reg      <= 1'b0;
            if (state_reg == IDLE && bus.start) begin
                head_row_reg <= 4'd8;
                head_col_reg <= 4'd8;
                dir_reg      <= DIR_R;
                pend_reg     <= DIR_R;
                len_reg      <= START_LEN_V;
                tick_reg     <= '0;
                food_row_reg <= lfsr_reg[7:4];
                food_col_reg <= start_food_col;
            end else if (state_reg == RUN) begin
                tick_reg <= step_cycle ? '0 : tick_reg + CW'(1);
                if (step_ok) begin
                    head_row_reg <= nxt_row5[3:0];
                    head_col_reg <= nxt_col5[3:0];
                    dir_reg      <= pend_reg;
                    tracking_reg <= 1'b1;
                    // A press in the step cycle is judged against the direction just committed.
                    if (press_valid && !opposite(press_dir, pend_reg)) pend_reg <= press_dir;
                    if (food_hit) begin
                        hit_reg      <= 1'b1;
                        len_reg      <= (len_reg < MAX_LEN_V) ? len_reg + 6'd1 : len_reg;
                        food_row_reg <= lfsr_reg[7:4];
                        food_col_reg <= hit_food_col;
                    end
                end else if (!step_cycle && press_valid && !opposite(press_dir, dir_reg)) begin
                    pend_reg <= press_dir;
                end
            end
        end
    end

    assign bus.next_row     = nxt_row5[3:0];
    assign bus.next_col     = nxt_col5[3:0];
    assign bus.head_row     = head_row_reg;
    assign bus.head_col     = head_col_reg;
    assign bus.L            = (dir_reg == DIR_L);
    assign bus.R            = (dir_reg == DIR_R);
    assign bus.U            = (dir_reg == DIR_U);
    assign bus.D            = (dir_reg == DIR_D);
    assign bus.tracking     = tracking_reg;
    assign bus.hit_score    = hit_reg;
    assign bus.snake_length = len_reg;
    assign bus.gameover     = (state_reg == OVER);
    assign bus.food_row     = food_row_reg;
    assign bus.food_col     = food_col_reg;
endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: directed game scenarios plus random play, all checked
// every cycle against a coordinate/vector model of the game rules.
module tb_snake_head_ctrl;
    localparam int TICK_DIV  = 4;
    localparam int START_LEN = 3;
    localparam int MAX_LEN   = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

    logic Clock = 1'b0;
    logic reset = 1'b0;
    snake_head_ctrl_if bus();

    snake_head_ctrl #(.TICK_DIV(TICK_DIV), .START_LEN(START_LEN), .MAX_LEN(MAX_LEN)) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: positions as signed ints, directions as (row,col) unit vectors.
    bit         m_valid = 0;
    int         m_mode, m_hr, m_hc, m_dr, m_dc, m_pr, m_pc, m_len, m_fr, m_fc, m_phase;
    bit         m_trk, m_hit;
    logic [7:0] m_lf;

    task automatic model_new_game();
        m_mode = M_IDLE; m_hr = 8; m_hc = 8; m_dr = 0; m_dc = 1; m_pr = 0; m_pc = 1;
        m_len = START_LEN; m_fr = 0; m_fc = 0; m_phase = 0; m_trk = 0; m_hit = 0;
    endtask

    task automatic draw_food(input logic [7:0] v, input int tr, input int tc);
        m_fr = int'(v[7:4]);
        m_fc = int'(v[3:0]);
        if (m_fr == tr && m_fc == tc) m_fc = (m_fc + 1) % 16;
    endtask

    task automatic get_press(output bit v, output int r, output int c);
        v = 1; r = 0; c = 0;
        if (bus.btn_U)      r = -1;
        else if (bus.btn_D) r = 1;
        else if (bus.btn_L) c = -1;
        else if (bus.btn_R) c = 1;
        else                v = 0;
    endtask

    task automatic model_step();
        logic [7:0] cur;
        bit pv;
        int pr, pc, nr, nc;
        if (!reset) begin
            m_lf = 8'h5A;
            model_new_game();
            m_valid = 1;
            return;
        end
        cur  = m_lf;
        m_lf = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
        m_trk = 0;
        m_hit = 0;
        get_press(pv, pr, pc);
        case (m_mode)
            M_IDLE: if (bus.start) begin
                model_new_game();
                m_mode = M_RUN;
                draw_food(cur, 8, 8);
            end
            M_RUN: begin
                if (m_phase == TICK_DIV - 1) begin
                    m_phase = 0;
                    nr = m_hr + m_pr;
                    nc = m_hc + m_pc;
                    if (nr < 0 || nr > 15 || nc < 0 || nc > 15 || bus.next_occupied) begin
                        m_mode = M_OVER;
                    end else begin
                        m_hr = nr; m_hc = nc; m_dr = m_pr; m_dc = m_pc; m_trk = 1;
                        if (nr == m_fr && nc == m_fc) begin
                            m_hit = 1;
                            if (m_len < MAX_LEN) m_len++;
                            draw_food(cur, nr, nc);
                        end
                    end
                end else begin
                    m_phase++;
                end
                if (m_mode == M_RUN && pv && !(pr == -m_dr && pc == -m_dc)) begin
                    m_pr = pr;
                    m_pc = pc;
                end
            end
            default: if (bus.start) model_new_game();
        endcase
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            model_step();
            #1;
            if (m_valid) begin
                chk("head_row", bus.head_row, m_hr);
                chk("head_col", bus.head_col, m_hc);
                chk("next_row", bus.next_row, (m_hr + m_pr) & 15);
                chk("next_col", bus.next_col, (m_hc + m_pc) & 15);
                chk("dir_L", bus.L, m_dc == -1);
                chk("dir_R", bus.R, m_dc == 1);
                chk("dir_U", bus.U, m_dr == -1);
                chk("dir_D", bus.D, m_dr == 1);
                chk("tracking", bus.tracking, m_trk);
                chk("hit_score", bus.hit_score, m_hit);
                chk("snake_length", bus.snake_length, m_len);
                chk("gameover", bus.gameover, m_mode == M_OVER);
                chk("food_row", bus.food_row, m_fr);
                chk("food_col", bus.food_col, m_fc);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // 0=U 1=D 2=L 3=R, held for one cycle
    task automatic press_btn(input int idx);
        bus.btn_U = (idx == 0); bus.btn_D = (idx == 1);
        bus.btn_L = (idx == 2); bus.btn_R = (idx == 3);
        cyc(1);
        bus.btn_U = 0; bus.btn_D = 0; bus.btn_L = 0; bus.btn_R = 0;
    endtask

    function automatic int steer();
        int dr, dc, vr, vc;
        dr = m_fr - m_hr;
        dc = m_fc - m_hc;
        if (dc != 0) begin vr = 0; vc = (dc > 0) ? 1 : -1; end
        else         begin vc = 0; vr = (dr > 0) ? 1 : -1; end
        if (vr == -m_dr && vc == -m_dc) begin
            if (vc != 0) begin
                vc = 0;
                vr = (dr != 0) ? ((dr > 0) ? 1 : -1) : ((m_hr > 0) ? -1 : 1);
            end else begin
                vr = 0;
                vc = (m_hc > 0) ? -1 : 1;
            end
        end
        if (vr == -1) return 0;
        if (vr == 1)  return 1;
        if (vc == -1) return 2;
        return 3;
    endfunction

    // Called at the negedge right after a step; returns at the negedge after the hit step.
    task automatic chase_food(input int exp_len);
        bit got = 0;
        for (int s = 0; s < 120 && !got && !bus.gameover; s++) begin
            press_btn(steer());
            cyc(TICK_DIV - 1);
            if (bus.hit_score) got = 1;
        end
        chk("food_reached", got, 1);
        chk("hit_with_tracking", bus.tracking, 1);
        chk("len_after_hit", bus.snake_length, exp_len);
        chk("food_not_head", (bus.food_row == bus.head_row) && (bus.food_col == bus.head_col), 0);
        $display("food hit: head=(%0d,%0d) len=%0d new food=(%0d,%0d)", bus.head_row, bus.head_col,
                 bus.snake_length, bus.food_row, bus.food_col);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_row"}, bus.head_row, 8);
        chk({tag, "_col"}, bus.head_col, 8);
        chk({tag, "_R"}, bus.R, 1);
        chk({tag, "_len"}, bus.snake_length, 3);
        chk({tag, "_food"}, {bus.food_row, bus.food_col}, 0);
        chk({tag, "_trk"}, bus.tracking, 0);
        chk({tag, "_over"}, bus.gameover, 0);
    endtask

    initial begin
        bus.btn_L = 0; bus.btn_R = 0; bus.btn_U = 0; bus.btn_D = 0;
        bus.start = 0; bus.next_occupied = 0;
        reset = 0;
        cyc(2);
        check_idle("reset");
        $display("reset: head=(%0d,%0d) len=%0d", bus.head_row, bus.head_col, bus.snake_length);
        reset = 1;
        cyc(1);
        chk("model_lfsr_first", m_lf, 8'hB4);

        // free run
        bus.start = 1; cyc(1); bus.start = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(TICK_DIV);
            chk("free_trk", bus.tracking, 1);
            chk("free_col", bus.head_col, 9 + k);
            chk("free_row", bus.head_row, 8);
            $display("free step %0d: head=(%0d,%0d)", k, bus.head_row, bus.head_col);
        end

        // reversal ignored, then turns
        press_btn(2); cyc(TICK_DIV - 1);
        chk("rev_col", bus.head_col, 12);
        chk("rev_R", bus.R, 1);
        press_btn(0); cyc(TICK_DIV - 1);
        chk("turn_row", bus.head_row, 7);
        chk("turn_U", bus.U, 1);
        press_btn(2); cyc(TICK_DIV - 1);
        chk("turnL_col", bus.head_col, 11);
        chk("turnL_L", bus.L, 1);
        bus.btn_U = 1; bus.btn_D = 1; cyc(1); bus.btn_U = 0; bus.btn_D = 0;
        cyc(TICK_DIV - 1);
        chk("ud_row", bus.head_row, 6);
        chk("ud_U", bus.U, 1);
        $display("turns done: head=(%0d,%0d)", bus.head_row, bus.head_col);

        // food and saturation
        chase_food((m_len < MAX_LEN) ? m_len + 1 : MAX_LEN);
        chase_food(4);

        // mid-run reset on the step edge
        cyc(TICK_DIV - 1);
        reset = 0; cyc(1); reset = 1;
        check_idle("midreset");
        cyc(TICK_DIV);
        chk("midreset_trk_later", bus.tracking, 0);
        $display("mid-run reset: head=(%0d,%0d)", bus.head_row, bus.head_col);

        // wall
        bus.start = 1; cyc(1); bus.start = 0;
        cyc(7 * TICK_DIV);
        chk("wall_col15", bus.head_col, 15);
        cyc(TICK_DIV);
        chk("wall_over", bus.gameover, 1);
        chk("wall_row", bus.head_row, 8);
        chk("wall_col", bus.head_col, 15);
        chk("wall_trk", bus.tracking, 0);
        $display("wall: gameover=%0d head=(%0d,%0d)", bus.gameover, bus.head_row, bus.head_col);
        bus.start = 1; cyc(1); bus.start = 0;
        check_idle("restart");

        // body hit
        bus.start = 1; cyc(1); bus.start = 0;
        cyc(TICK_DIV - 1);
        bus.next_occupied = 1; cyc(1); bus.next_occupied = 0;
        chk("body_over", bus.gameover, 1);
        chk("body_row", bus.head_row, 8);
        chk("body_col", bus.head_col, 8);
        chk("body_trk", bus.tracking, 0);
        $display("body hit: gameover=%0d", bus.gameover);
        bus.start = 1; cyc(1); bus.start = 0;

        // random play
        for (int i = 0; i < 3000; i++) begin
            int b;
            b = int'($urandom_range(0, 7));
            bus.btn_U = (b == 0); bus.btn_D = (b == 1);
            bus.btn_L = (b == 2); bus.btn_R = (b == 3);
            bus.start         = ($urandom_range(0, 29) == 0);
            bus.next_occupied = ($urandom_range(0, 15) == 0);
            reset             = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        bus.btn_U = 0; bus.btn_D = 0; bus.btn_L = 0; bus.btn_R = 0;
        bus.start = 0; bus.next_occupied = 0; reset = 1;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
